popcount_seq: RTL and testbench

//  Sequential, parametrised ones-counter for the oversampled sample vector
//  (SAMPLES*OSF bits). It accepts one vector over a valid/ready handshake and

---
 rtl/popcount_seq_if.sv | 26 ++
 rtl/popcount_seq.sv | 104 ++++++++++
 tb/tb_popcount_seq.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/popcount_seq_if.sv
// Handshake bundle for popcount_seq: the vector/threshold input channel,
// the count/flag result channel and the busy indicator.
interface popcount_seq_if #(
    parameter int N  = 1024,
    parameter int CW = 11
);
    logic          In_Valid;
    logic          In_Ready;
    logic [N-1:0]  Input;
    logic [CW-1:0] Thresh;
    logic          Out_Valid;
    logic          Out_Ready;
    logic [CW-1:0] Output;
    logic          Above;
    logic          Busy;

    modport master (
        output In_Valid, Input, Thresh, Out_Ready,
        input  In_Ready, Out_Valid, Output, Above, Busy
    );

    modport slave (
        input  In_Valid, Input, Thresh, Out_Ready,
        output In_Ready, Out_Valid, Output, Above, Busy
    );
endinterface

// File: rtl/popcount_seq.sv
// Sequential ones-counter for the oversampled sample vector. A captured
// vector is consumed CHUNK bits per clock from the low end of a shift
// register; the final count and a threshold flag are then held on the
// result channel until the consumer takes them.
//
//   state | meaning
//   IDLE  | ready for a new vector
//   COUNT | summing one chunk per cycle, NCHUNK cycles in total
//   DONE  | result presented, waiting for the result handshake
module popcount_seq #(
    parameter int SAMPLES = 128,
    parameter int OSF     = 8,
    parameter int CHUNK   = 64
) (
    input  logic           CLK,
    input  logic           RST,
    popcount_seq_if.slave  bus
);
    localparam int N      = SAMPLES * OSF;
    localparam int NCHUNK = N / CHUNK;
    localparam int CW     = $clog2(N) + 1;
    localparam int PW     = $clog2(CHUNK) + 1;
    localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IW-1:0] IDX_LAST = IW'(NCHUNK - 1);

    if (N % CHUNK != 0) begin : g_bad_chunk
        $error("popcount_seq: SAMPLES*OSF must be a multiple of CHUNK");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t        state;
    logic [N-1:0]  shreg;
    logic [CW-1:0] thresh_q;
    logic [CW-1:0] acc;
    logic [IW-1:0] idx;
    logic [CW-1:0] out_q;
    logic          above_q;
    logic          out_valid_q;

    logic [PW-1:0] chunk_pop;
    logic [CW-1:0] sum_next;

    // Ones in the chunk currently at the bottom of the shift register.
    always_comb begin
        chunk_pop = '0;
        for (int i = 0; i < CHUNK; i++) begin
            chunk_pop = chunk_pop + PW'(shreg[i]);
        end
        sum_next = acc + CW'(chunk_pop);
    end

    // Sequencer: capture, per-chunk accumulation, result hold until taken.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= IDLE;
            idx         <= '0;
            out_q       <= '0;
            above_q     <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.In_Valid && bus.In_Ready) begin
                        shreg    <= bus.Input;
                        thresh_q <= bus.Thresh;
                        acc      <= '0;
                        idx      <= '0;
                        state    <= COUNT;
                    end
                end
                COUNT: begin
                    acc   <= sum_next;
                    shreg <= shreg >> CHUNK;
                    idx   <= idx + 1'b1;
                    if (idx == IDX_LAST) begin
                        out_q       <= sum_next;
                        above_q     <= (sum_next >= thresh_q);
                        out_valid_q <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    if (bus.Out_Ready) begin
                        out_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Ready is withheld during reset so no vector is taken in that cycle.
    assign bus.In_Ready  = (state == IDLE) && !RST;
    assign bus.Busy      = (state != IDLE);
    assign bus.Out_Valid = out_valid_q;
    assign bus.Output    = out_q;
    assign bus.Above     = above_q;
endmodule

// File: tb/tb_popcount_seq.sv
// Bench for popcount_seq: two instances (CHUNK=64 and CHUNK=N), a shared
// scoreboard per instance fed at input acceptance, and a monitor per
// instance that checks latency, count and flag at each result.
module tb_popcount_seq;
    localparam int N  = 1024;
    localparam int CW = 11;

    typedef struct {
        int cnt;
        bit above;
        int acc_cyc;
    } exp_t;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    logic          rst[2];
    logic          in_valid[2];
    logic [N-1:0]  in_data[2];
    logic [CW-1:0] in_th[2];
    logic          out_ready[2];
    logic          in_ready[2];
    logic          out_valid[2];
    logic [CW-1:0] out_val[2];
    logic          above[2];
    logic          busy[2];

    exp_t sbq[2][$];
    bit   seen[2];

    popcount_seq_if #(.N(N), .CW(CW)) ifa ();
    popcount_seq_if #(.N(N), .CW(CW)) ifw ();

    popcount_seq #(.SAMPLES(128), .OSF(8), .CHUNK(64))   dut_a (.CLK(CLK), .RST(rst[0]), .bus(ifa));
    popcount_seq #(.SAMPLES(128), .OSF(8), .CHUNK(1024)) dut_w (.CLK(CLK), .RST(rst[1]), .bus(ifw));

    assign ifa.In_Valid  = in_valid[0];
    assign ifa.Input     = in_data[0];
    assign ifa.Thresh    = in_th[0];
    assign ifa.Out_Ready = out_ready[0];
    assign in_ready[0]   = ifa.In_Ready;
    assign out_valid[0]  = ifa.Out_Valid;
    assign out_val[0]    = ifa.Output;
    assign above[0]      = ifa.Above;
    assign busy[0]       = ifa.Busy;

    assign ifw.In_Valid  = in_valid[1];
    assign ifw.Input     = in_data[1];
    assign ifw.Thresh    = in_th[1];
    assign ifw.Out_Ready = out_ready[1];
    assign in_ready[1]   = ifw.In_Ready;
    assign out_valid[1]  = ifw.Out_Valid;
    assign out_val[1]    = ifw.Output;
    assign above[1]      = ifw.Above;
    assign busy[1]       = ifw.Busy;

    task automatic check(string name, int act, int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: actual %0d required %0d", name, act, req);
        end
    endtask

    task automatic flag_fail(string name);
        checks++;
        errors++;
        $display("FAIL %s: actual timeout/unexpected required event", name);
    endtask

    // Reference: the count is simply the number of set bits; the flag is
    // an unsigned at-or-above compare against the captured threshold.
    function automatic exp_t expect_of(logic [N-1:0] v, logic [CW-1:0] th, int acc_cyc);
        exp_t e;
        e.cnt     = $countones(v);
        e.above   = (e.cnt >= int'(th));
        e.acc_cyc = acc_cyc;
        return e;
    endfunction

    function automatic logic [N-1:0] rand_words();
        logic [N-1:0] v;
        for (int w = 0; w < N / 32; w++) v[w*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [N-1:0] gen_vec();
        logic [N-1:0] v;
        v = rand_words();
        case ($urandom_range(0, 9))
            0: v = '0;
            1: v = '1;
            2: v = v & (v >> 1) & (v >> 3);
            3: v = v | (v << 2);
            4: begin v = '0; v[$urandom_range(0, N-1)] = 1'b1; end
            default: ;
        endcase
        return v;
    endfunction

    function automatic logic [CW-1:0] gen_th(int cnt);
        case ($urandom_range(0, 3))
            0:       return CW'(cnt);
            1:       return CW'(cnt + 1);
            2:       return CW'((cnt > 0) ? cnt - 1 : 0);
            default: return CW'($urandom_range(0, N + 2));
        endcase
    endfunction

    // Present one vector and wait (bounded) for it to be accepted.
    task automatic send(int d, logic [N-1:0] v, logic [CW-1:0] th);
        @(posedge CLK); #1;
        in_valid[d] = 1'b1;
        in_data[d]  = v;
        in_th[d]    = th;
        for (int k = 0; k < 200; k++) begin
            @(negedge CLK);
            if (in_ready[d]) begin
                sbq[d].push_back(expect_of(v, th, cyc + 1));
                @(posedge CLK); #1;
                in_valid[d] = 1'b0;
                return;
            end
            @(posedge CLK); #1;
        end
        flag_fail($sformatf("dut%0d_send_timeout", d));
        in_valid[d] = 1'b0;
    endtask

    task automatic drain(int d);
        for (int k = 0; k < 3000; k++) begin
            @(negedge CLK);
            if (sbq[d].size() == 0 && !out_valid[d]) return;
        end
        flag_fail($sformatf("dut%0d_drain_timeout", d));
    endtask

    task automatic run_rand(int d, int nvec);
        int sent = 0;
        int guard = 0;
        bit hold = 0;
        logic [N-1:0] v;
        while (sent < nvec && guard < 60000) begin
            @(posedge CLK); #1;
            guard++;
            out_ready[d] = ($urandom_range(0, 3) != 0);
            if (!hold) begin
                if ($urandom_range(0, 3) != 0) begin
                    v = gen_vec();
                    in_data[d]  = v;
                    in_th[d]    = gen_th($countones(v));
                    in_valid[d] = 1'b1;
                    hold = 1;
                end else begin
                    in_valid[d] = 1'b0;
                    in_data[d]  = rand_words();
                end
            end
            @(negedge CLK);
            if (in_valid[d] && in_ready[d]) begin
                sbq[d].push_back(expect_of(in_data[d], in_th[d], cyc + 1));
                sent++;
                hold = 0;
            end
        end
        if (sent < nvec) flag_fail($sformatf("dut%0d_random_timeout", d));
        @(posedge CLK); #1;
        in_valid[d]  = 1'b0;
        out_ready[d] = 1'b1;
    endtask

    // Result monitors: latency on first sight of a result, values on handshake.
    for (genvar g = 0; g < 2; g++) begin : g_mon
        initial begin
            exp_t e;
            forever begin
                @(negedge CLK);
                if (rst[g]) begin
                    seen[g] = 0;
                end else if (out_valid[g]) begin
                    if (sbq[g].size() == 0) begin
                        if (!seen[g]) flag_fail($sformatf("dut%0d_unexpected_result", g));
                        seen[g] = 1;
                        if (out_ready[g]) seen[g] = 0;
                    end else begin
                        if (!seen[g]) begin
                            seen[g] = 1;
                            check($sformatf("dut%0d_latency", g), cyc - sbq[g][0].acc_cyc, (g == 0) ? 16 : 1);
                        end
                        if (out_ready[g]) begin
                            e = sbq[g].pop_front();
                            seen[g] = 0;
                            check($sformatf("dut%0d_output", g), int'(out_val[g]), e.cnt);
                            check($sformatf("dut%0d_above", g), int'(above[g]), int'(e.above));
                        end
                    end
                end
            end
        end
    end

    initial begin
        logic [N-1:0]  v;
        logic [CW-1:0] th;
        exp_t          e;
        bit            got;

        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; in_valid[d] = 1'b0; in_data[d] = '0; in_th[d] = '0;
            out_ready[d] = 1'b1; seen[d] = 0;
        end
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("dut%0d_rst_in_ready", d), int'(in_ready[d]), 0);
            check($sformatf("dut%0d_rst_out_valid", d), int'(out_valid[d]), 0);
            check($sformatf("dut%0d_rst_busy", d), int'(busy[d]), 0);
            check($sformatf("dut%0d_rst_output", d), int'(out_val[d]), 0);
            check($sformatf("dut%0d_rst_above", d), int'(above[d]), 0);
        end
        @(posedge CLK); #1;
        rst[0] = 1'b0; rst[1] = 1'b0;
        @(negedge CLK);
        check("idle_in_ready", int'(in_ready[0]), 1);

        // zeros, zero threshold; then all-ones at and above N
        send(0, '0, '0);
        send(0, '1, CW'(1024));
        send(0, '1, CW'(1025));
        // first and last chunk coverage
        v = '0; v[N-1] = 1'b1; send(0, v, CW'(1));
        v = '0; v[0] = 1'b1;   send(0, v, CW'(2));
        drain(0);

        // result held under back-pressure while the input side churns
        out_ready[0] = 1'b0;
        v  = rand_words();
        th = gen_th($countones(v));
        e  = expect_of(v, th, 0);
        send(0, v, th);
        got = 0;
        for (int k = 0; k < 100 && !got; k++) begin
            @(negedge CLK);
            got = out_valid[0];
        end
        if (!got) flag_fail("stall_wait_valid");
        for (int k = 0; k < 5; k++) begin
            @(posedge CLK); #1;
            in_valid[0] = 1'b1;
            in_data[0]  = rand_words();
            in_th[0]    = CW'($urandom);
            @(negedge CLK);
            check("stall_output", int'(out_val[0]), e.cnt);
            check("stall_above", int'(above[0]), int'(e.above));
            check("stall_in_ready", int'(in_ready[0]), 0);
            check("stall_out_valid", int'(out_valid[0]), 1);
        end
        @(posedge CLK); #1;
        out_ready[0] = 1'b1;
        in_valid[0]  = 1'b0;
        @(posedge CLK); #1;
        @(negedge CLK);
        check("post_done_in_ready", int'(in_ready[0]), 1);
        check("post_done_busy", int'(busy[0]), 0);
        check("post_done_out_valid", int'(out_valid[0]), 0);
        check("post_done_output_held", int'(out_val[0]), e.cnt);
        check("post_done_above_held", int'(above[0]), int'(e.above));

        // reset in the middle of counting abandons the vector
        send(0, '1, '0);
        repeat (7) @(posedge CLK);
        #1;
        rst[0] = 1'b1;
        @(negedge CLK);
        check("mid_rst_in_ready", int'(in_ready[0]), 0);
        check("mid_rst_busy_before", int'(busy[0]), 1);
        @(posedge CLK); #1;
        rst[0] = 1'b0;
        void'(sbq[0].pop_back());
        @(negedge CLK);
        check("mid_rst_out_valid", int'(out_valid[0]), 0);
        check("mid_rst_busy", int'(busy[0]), 0);
        check("mid_rst_in_ready_after", int'(in_ready[0]), 1);
        check("mid_rst_output", int'(out_val[0]), 0);
        v = '0; v[3:0] = 4'hF;
        send(0, v, CW'(4));
        drain(0);

        fork
            run_rand(0, 1000);
            run_rand(1, 1000);
        join
        drain(0);
        drain(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
